// File: rtl/counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Package : counter_pkg                                                |
// | Brief   : Mode/state enumerations and load clamp helper shared by    |
// |           the up/down counter.                                       |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package counter_pkg;

    typedef enum logic [1:0] {
        MODE_WRAP    = 2'd0,
        MODE_SAT     = 2'd1,
        MODE_ONESHOT = 2'd2
    } mode_t;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_DONE = 1'b1
    } state_t;

    // Clamp a load value into the legal count range 0..max.
    function automatic longint unsigned clamp_val(input longint unsigned din,
                                                  input longint unsigned max);
        return (din > max) ? max : din;
    endfunction

endpackage : counter_pkg
`default_nettype wire

// File: rtl/mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : mod_updown_counter                                         |
// | Brief   : Up/down counter with programmable modulus, clamped load,   |
// |           registered terminal-count pulse and WRAP / SAT / ONESHOT   |
// |           behaviour. Optional compare port under COUNTER_MATCH_EN.   |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int unsigned      WIDTH   = 8,
    parameter longint unsigned  MAX_VAL = (64'd1 << WIDTH) - 64'd1,
    parameter mode_t            MODE    = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] din,
    input  logic             inc,
    input  logic             dec,
    output logic [WIDTH-1:0] cnt,
    output logic             tc,
    output logic             done
`ifdef COUNTER_MATCH_EN
    ,
    input  logic [WIDTH-1:0] cmp,
    output logic             match
`endif
);

    // Terminal value at WIDTH+1 bits so the incremented value never overflows the compare.
    localparam logic [WIDTH:0]   c_max_ext = MAX_VAL[WIDTH:0];
    localparam logic [WIDTH-1:0] c_max     = MAX_VAL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] c_zero    = '0;

    // Parameter legality check at elaboration.
    generate
        if (WIDTH < 2) begin : g_chk_width
            $error("mod_updown_counter: WIDTH must be >= 2");
        end
        if (MAX_VAL > ((64'd1 << WIDTH) - 64'd1)) begin : g_chk_max
            $error("mod_updown_counter: MAX_VAL exceeds 2**WIDTH-1");
        end
    endgenerate

    logic [WIDTH-1:0] r_cnt;
    logic             r_tc;
    state_t           r_state;

    logic [WIDTH-1:0] w_cnt_nxt;
    logic             w_tc_nxt;
    state_t           w_state_nxt;
    logic             w_up;
    logic             w_dn;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH-1:0] w_load_val;

    assign w_up       = inc & ~dec;
    assign w_dn       = dec & ~inc;
    assign w_sum      = {1'b0, r_cnt} + {{WIDTH{1'b0}}, 1'b1};
    assign w_load_val = WIDTH'(clamp_val(64'(din), MAX_VAL));

    // Register the count, terminal pulse and one-shot state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_tc    <= 1'b0;
            r_state <= ST_RUN;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_tc    <= w_tc_nxt;
            r_state <= w_state_nxt;
        end
    end

    // Next count / pulse / state: load wins over stepping; a DONE one-shot ignores steps.
    always_comb begin
        w_cnt_nxt   = r_cnt;
        w_tc_nxt    = 1'b0;
        w_state_nxt = r_state;
        if (load) begin
            w_cnt_nxt   = w_load_val;
            w_state_nxt = ST_RUN;
        end else if (r_state == ST_RUN) begin
            if (w_up) begin
                if (w_sum > c_max_ext) begin
                    // Stepping up from the terminal value.
                    if (MODE == MODE_WRAP) begin
                        w_cnt_nxt = c_zero;
                        w_tc_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = w_sum[WIDTH-1:0];
                    if ((w_sum == c_max_ext) && (MODE != MODE_WRAP)) begin
                        w_tc_nxt = 1'b1;
                        if (MODE == MODE_ONESHOT) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end else if (w_dn) begin
                if (r_cnt == c_zero) begin
                    // Stepping down from zero.
                    if (MODE == MODE_WRAP) begin
                        w_cnt_nxt = c_max;
                        w_tc_nxt  = 1'b1;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                    if ((r_cnt == {{(WIDTH-1){1'b0}}, 1'b1}) && (MODE != MODE_WRAP)) begin
                        w_tc_nxt = 1'b1;
                        if (MODE == MODE_ONESHOT) begin
                            w_state_nxt = ST_DONE;
                        end
                    end
                end
            end
        end
    end

    assign cnt  = r_cnt;
    assign tc   = r_tc;
    assign done = (MODE == MODE_ONESHOT) && (r_state == ST_DONE);

`ifdef COUNTER_MATCH_EN
    assign match = (r_cnt == cmp);
`endif

endmodule : mod_updown_counter
`default_nettype wire

// File: tb/tb_mod_updown_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_mod_updown_counter                                      |
// | Brief   : Directed self-checking bench for mod_updown_counter in     |
// |           WRAP, SAT and ONESHOT modes plus a 16-bit cascade.         |
// | Rev     : 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_mod_updown_counter;
    import counter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // WRAP instance
    logic       wr_load = 0, wr_inc = 0, wr_dec = 0;
    logic [3:0] wr_din = 0;
    logic [3:0] wr_cnt;
    logic       wr_tc, wr_done;
    // SAT instance
    logic       sa_load = 0, sa_inc = 0, sa_dec = 0;
    logic [3:0] sa_din = 0;
    logic [3:0] sa_cnt;
    logic       sa_tc, sa_done;
    // ONESHOT instance
    logic       os_load = 0, os_inc = 0, os_dec = 0;
    logic [3:0] os_din = 0;
    logic [3:0] os_cnt;
    logic       os_tc, os_done;
    // 8-bit cascade
    logic       lo_load = 0, lo_inc = 0, hi_load = 0;
    logic [7:0] lo_din = 0, hi_din = 0;
    logic [7:0] lo_cnt, hi_cnt;
    logic       lo_tc, hi_tc, lo_done, hi_done;
`ifdef COUNTER_MATCH_EN
    logic [3:0] wr_cmp = 4'd6, sa_cmp = 0, os_cmp = 0;
    logic [7:0] lo_cmp = 0, hi_cmp = 0;
    logic       wr_match, sa_match, os_match, lo_match, hi_match;
`endif

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_WRAP)) u_wrap (
        .clk(clk), .rst(rst), .load(wr_load), .din(wr_din), .inc(wr_inc), .dec(wr_dec),
        .cnt(wr_cnt), .tc(wr_tc), .done(wr_done)
`ifdef COUNTER_MATCH_EN
        , .cmp(wr_cmp), .match(wr_match)
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_SAT)) u_sat (
        .clk(clk), .rst(rst), .load(sa_load), .din(sa_din), .inc(sa_inc), .dec(sa_dec),
        .cnt(sa_cnt), .tc(sa_tc), .done(sa_done)
`ifdef COUNTER_MATCH_EN
        , .cmp(sa_cmp), .match(sa_match)
`endif
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VAL(9), .MODE(MODE_ONESHOT)) u_one (
        .clk(clk), .rst(rst), .load(os_load), .din(os_din), .inc(os_inc), .dec(os_dec),
        .cnt(os_cnt), .tc(os_tc), .done(os_done)
`ifdef COUNTER_MATCH_EN
        , .cmp(os_cmp), .match(os_match)
`endif
    );

    mod_updown_counter #(.WIDTH(8), .MAX_VAL(255), .MODE(MODE_WRAP)) u_lo (
        .clk(clk), .rst(rst), .load(lo_load), .din(lo_din), .inc(lo_inc), .dec(1'b0),
        .cnt(lo_cnt), .tc(lo_tc), .done(lo_done)
`ifdef COUNTER_MATCH_EN
        , .cmp(lo_cmp), .match(lo_match)
`endif
    );

    mod_updown_counter #(.WIDTH(8), .MAX_VAL(255), .MODE(MODE_WRAP)) u_hi (
        .clk(clk), .rst(rst), .load(hi_load), .din(hi_din), .inc(lo_tc), .dec(1'b0),
        .cnt(hi_cnt), .tc(hi_tc), .done(hi_done)
`ifdef COUNTER_MATCH_EN
        , .cmp(hi_cmp), .match(hi_match)
`endif
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        // Reset
        step(); step();
        chk("rst_wr_cnt", 32'(wr_cnt), 0);
        chk("rst_wr_tc",  32'(wr_tc), 0);
        chk("rst_os_done", 32'(os_done), 0);
        rst = 0;

        // 1: WRAP up through 9 -> 0, then down from 0 -> 9
        wr_inc = 1;
        for (int i = 1; i <= 10; i++) begin
            step();
            chk($sformatf("wrap_up_cnt%0d", i), 32'(wr_cnt), 32'(i % 10));
            chk($sformatf("wrap_up_tc%0d", i),  32'(wr_tc), (i == 10) ? 1 : 0);
        end
        wr_inc = 0; wr_dec = 1;
        step();
        chk("wrap_dn_cnt", 32'(wr_cnt), 9);
        chk("wrap_dn_tc",  32'(wr_tc), 1);
        wr_dec = 0;
        step();
        chk("wrap_idle_tc", 32'(wr_tc), 0);
        chk("wrap_idle_cnt", 32'(wr_cnt), 9);

        // 2: SAT
        sa_load = 1; sa_din = 8;
        step();
        chk("sat_load_cnt", 32'(sa_cnt), 8);
        chk("sat_load_tc",  32'(sa_tc), 0);
        sa_load = 0; sa_inc = 1;
        step();
        chk("sat_up1_cnt", 32'(sa_cnt), 9);
        chk("sat_up1_tc",  32'(sa_tc), 1);
        step();
        chk("sat_up2_cnt", 32'(sa_cnt), 9);
        chk("sat_up2_tc",  32'(sa_tc), 0);
        step();
        chk("sat_up3_cnt", 32'(sa_cnt), 9);
        chk("sat_up3_tc",  32'(sa_tc), 0);
        sa_inc = 0; sa_load = 1; sa_din = 1;
        step();
        sa_load = 0; sa_dec = 1;
        step();
        chk("sat_dn1_cnt", 32'(sa_cnt), 0);
        chk("sat_dn1_tc",  32'(sa_tc), 1);
        step();
        chk("sat_dn2_cnt", 32'(sa_cnt), 0);
        chk("sat_dn2_tc",  32'(sa_tc), 0);
        sa_dec = 0;

        // 3: ONESHOT
        os_load = 1; os_din = 7;
        step();
        os_load = 0; os_inc = 1;
        step();
        chk("os_s1_cnt", 32'(os_cnt), 8);
        chk("os_s1_tc",  32'(os_tc), 0);
        chk("os_s1_done", 32'(os_done), 0);
        step();
        chk("os_s2_cnt", 32'(os_cnt), 9);
        chk("os_s2_tc",  32'(os_tc), 1);
        chk("os_s2_done", 32'(os_done), 1);
        step();
        chk("os_s3_cnt", 32'(os_cnt), 9);
        chk("os_s3_tc",  32'(os_tc), 0);
        chk("os_s3_done", 32'(os_done), 1);
        os_inc = 0; os_dec = 1;
        step();
        chk("os_s4_cnt", 32'(os_cnt), 9);
        chk("os_s4_tc",  32'(os_tc), 0);
        chk("os_s4_done", 32'(os_done), 1);
        os_dec = 0; os_load = 1; os_din = 3;
        step();
        chk("os_reload_cnt", 32'(os_cnt), 3);
        chk("os_reload_done", 32'(os_done), 0);
        os_load = 0; os_inc = 1;
        step();
        chk("os_rerun_cnt", 32'(os_cnt), 4);
        chk("os_rerun_tc",  32'(os_tc), 0);
        os_inc = 0;

        // 4: priority / corner cases
        wr_load = 1; wr_din = 4;
        step();
        wr_load = 0; wr_inc = 1; wr_dec = 1;
        step();
        chk("both_hold_cnt", 32'(wr_cnt), 4);
        chk("both_hold_tc",  32'(wr_tc), 0);
        wr_dec = 0; wr_load = 1; wr_din = 12;
        step();
        chk("clamp_cnt", 32'(wr_cnt), 9);
        chk("clamp_tc",  32'(wr_tc), 0);
        wr_din = 5;
        os_load = 1; os_din = 8;
        step();
        chk("mid_cnt", 32'(wr_cnt), 5);
        wr_load = 0; os_load = 0; os_inc = 1;
        step();
        chk("mid_wr_cnt", 32'(wr_cnt), 6);
        chk("pre_rst_os_done", 32'(os_done), 1);
        rst = 1;
        step();
        chk("rst_mid_wr_cnt", 32'(wr_cnt), 0);
        chk("rst_mid_os_cnt", 32'(os_cnt), 0);
        chk("rst_mid_os_done", 32'(os_done), 0);
        rst = 0; wr_inc = 0; os_inc = 0;

        // 5: 8-bit wrap and 16-bit cascade rollover at 0xFFFF
        lo_load = 1; lo_din = 8'hFF; hi_load = 1; hi_din = 8'hFF;
        step();
        chk("casc_load", 32'({hi_cnt, lo_cnt}), 32'hFFFF);
        lo_load = 0; hi_load = 0; lo_inc = 1;
        step();
        lo_inc = 0;
        chk("lo_wrap_cnt", 32'(lo_cnt), 0);
        chk("lo_wrap_tc",  32'(lo_tc), 1);
        chk("hi_pre_cnt",  32'(hi_cnt), 8'hFF);
        step();
        chk("casc_cnt", 32'({hi_cnt, lo_cnt}), 0);
        chk("hi_wrap_tc", 32'(hi_tc), 1);
        chk("lo_tc_clear", 32'(lo_tc), 0);

`ifdef COUNTER_MATCH_EN
        // 6: compare output tracks cnt == cmp
        wr_load = 1; wr_din = 0;
        step();
        wr_load = 0; wr_inc = 1;
        chk("match_0", 32'(wr_match), 0);
        for (int i = 1; i <= 8; i++) begin
            step();
            chk($sformatf("match_%0d", i), 32'(wr_match), (i == 6) ? 1 : 0);
        end
        wr_inc = 0;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_mod_updown_counter
`default_nettype wire
